ad9910_spi_master: RTL

SPI transaction controller for the AD9910 DDS serial port. Accepts one instruction byte plus 1–4 data bytes, drives CSB/SCLK/SDIO, and for read instructions generates the per-bit sample strobe, sampled bit and clear pulse that feed the 32-bit receive shift register directly downstream. It sits between the host register interface and the DDS pins.

---
 rtl/ad9910_spi_pkg.sv | 27 ++
 rtl/ad9910_spi_tx_shifter.sv | 43 ++++
 rtl/ad9910_spi_master.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ad9910_spi_pkg.sv
// Shared types and constants for the AD9910 serial-port controller.
package ad9910_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } spi_state_t;

  localparam int INSTR_READ_BIT = 7;
  localparam int INSTR_W        = 8;
  localparam int DATA_W         = 32;
  localparam int FRAME_W        = INSTR_W + DATA_W;

  // Data bits carried by a frame: 8, 16, 24 or 32.
  function automatic logic [5:0] data_bits_of(input logic [1:0] data_len);
    return 6'({data_len, 3'b000}) + 6'd8;
  endfunction

  // Total bits in a frame, instruction byte included.
  function automatic logic [5:0] frame_bits_of(input logic [1:0] data_len);
    return data_bits_of(data_len) + 6'd8;
  endfunction

endpackage

// File: rtl/ad9910_spi_tx_shifter.sv
// 40-bit parallel-load transmit shifter; instruction and data are packed so the
// first bit on the wire always sits at the end selected by lsb_first.
module ad9910_spi_tx_shifter
  import ad9910_spi_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic               lsb_first,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [1:0]         data_len,
  output logic               bit_out
);

  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] frame;
  logic               dir_lsb;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    frame = '0;
    if (lsb_first) frame = {wdata, instr};
    else           frame = {instr, wdata << (6'd24 - 6'({data_len, 3'b000}))};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      dir_lsb <= 1'b0;
    end else if (load) begin
      sr      <= frame;
      dir_lsb <= lsb_first;
    end else if (shift) begin
      sr <= dir_lsb ? {1'b0, sr[FRAME_W-1:1]} : {sr[FRAME_W-2:0], 1'b0};
    end
  end

  assign bit_out = dir_lsb ? sr[0] : sr[FRAME_W-1];

endmodule

// File: rtl/ad9910_spi_master.sv
// AD9910 SPI transaction controller: CSB/SCLK/SDIO sequencing plus read strobes.
// Define AD9910_SPI_3WIRE_EN to release SDIO during the data phase of reads.
module ad9910_spi_master
  import ad9910_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [1:0]         data_len,
  input  logic               lsb_first,
  input  logic               miso,
  output logic               busy,
  output logic               done,
  output logic               csb,
  output logic               sclk,
  output logic               sdio_out,
  output logic               sdio_oe,
  output logic               rx_clear,
  output logic               rx_strobe,
  output logic               rx_bit,
  output logic               rx_lsb_first
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DONE_AT  = 8'(CLK_DIV - 2);

  spi_state_t state;
  logic [7:0] cnt;
  logic [5:0] bit_cnt;
  logic [5:0] data_bits;
  logic       is_read;
  logic       last;
  logic       accept;
  logic       shift;

  assign last     = (cnt == DIV_LAST);
  assign accept   = (state == IDLE) && start && !reset;
  assign shift    = (state == SHIFT_HI) && last && (bit_cnt != 6'd0);
  // The downstream receive register must be cleared in the accept cycle itself.
  assign rx_clear = accept && instr[INSTR_READ_BIT];

  ad9910_spi_tx_shifter u_tx (
    .clk       (CLK100MHZ),
    .reset     (reset),
    .load      (accept),
    .shift     (shift),
    .lsb_first (lsb_first),
    .instr     (instr),
    .wdata     (wdata),
    .data_len  (data_len),
    .bit_out   (sdio_out)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      data_bits    <= '0;
      is_read      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      csb          <= 1'b1;
      sclk         <= 1'b0;
      rx_strobe    <= 1'b0;
      rx_bit       <= 1'b0;
      rx_lsb_first <= 1'b0;
    end else begin
      done      <= 1'b0;
      rx_strobe <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state        <= SHIFT_LO;
          cnt          <= '0;
          bit_cnt      <= frame_bits_of(data_len) - 6'd1;
          data_bits    <= data_bits_of(data_len);
          is_read      <= instr[INSTR_READ_BIT];
          rx_lsb_first <= lsb_first;
          busy         <= 1'b1;
          csb          <= 1'b0;
        end
        SHIFT_LO: if (last) begin
          state <= SHIFT_HI;
          cnt   <= '0;
          sclk  <= 1'b1;
        end else cnt <= cnt + 8'd1;
        SHIFT_HI: if (last) begin
          cnt  <= '0;
          sclk <= 1'b0;
          // Bits below data_bits belong to the data phase; only those are sampled.
          if (is_read && (bit_cnt < data_bits)) begin
            rx_strobe <= 1'b1;
            rx_bit    <= miso;
          end
          if (bit_cnt == 6'd0) state <= HOLD;
          else begin
            state   <= SHIFT_LO;
            bit_cnt <= bit_cnt - 6'd1;
          end
        end else cnt <= cnt + 8'd1;
        HOLD: if (last) begin
          state <= GAP;
          cnt   <= '0;
          csb   <= 1'b1;
          if (CLK_DIV == 1) done <= 1'b1;
        end else cnt <= cnt + 8'd1;
        GAP: if (last) begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt + 8'd1;
          if (cnt == DONE_AT) done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AD9910_SPI_3WIRE_EN
  // SDIO is released from the first data bit of a read until the frame returns to IDLE.
  always_ff @(posedge CLK100MHZ) begin
    if (reset)
      sdio_oe <= 1'b1;
    else if ((state == SHIFT_HI) && last && is_read && (bit_cnt == data_bits))
      sdio_oe <= 1'b0;
    else if ((state == GAP) && last)
      sdio_oe <= 1'b1;
  end
`else
  assign sdio_oe = 1'b1;
`endif

endmodule
